axi_write_arbiter: RTL and testbench
====================================

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: TIMEOUT, 255, max cycles waited for ready before abort (1..65535).
REQ-003 ACLK  input  1  clock; all logic on rising edge.
REQ-004 ARESET  input  1  synchronous reset, active-high.
REQ-005 req_valid  input  2  per-requester write request; bit i = requester i.
REQ-006 req_addr  input  64  requester i address in bits [32i+31:32i].
REQ-007 req_data  input  64  requester i write data in bits [32i+31:32i].
REQ-008 req_strb  input  8  requester i byte strobes in bits [4i+3:4i].
REQ-009 req_accept  output  2  one-cycle pulse: request i latched.
REQ-010 req_done  output  2  one-cycle pulse: request i completed.
REQ-011 req_err  output  2  one-cycle pulse: request i aborted by timeout.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 valid  output  1  one-cycle start pulse to the AXI write master user port.
REQ-014 aw_addr  output  32  write address to the master.
REQ-015 w_data  output  32  write data to the master.
REQ-016 w_strb  output  4  byte strobes to the master.
REQ-017 ready  input  1  master completion; first high sample in WAIT ends the transaction.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and WAIT; all outputs SHALL be registered.
REQ-019 IDLE: with any req_valid bit high, grant per REQ-020, latch the winner's addr/data/strb and id, go to ISSUE next edge; otherwise stay.
REQ-020 Arbitration: single request wins; both high -> requester != last_grant wins (round-robin); last_grant resets to 1 so requester 0 wins the first tie.
REQ-021 ISSUE (exactly one cycle): valid=1, req_accept[id]=1, aw_addr/w_data/w_strb = latched values; go to WAIT.
REQ-022 WAIT: valid=0; aw_addr/w_data/w_strb held stable; 16-bit wait counter increments each cycle from 0.
REQ-023 WAIT with ready=1: next cycle req_done[id]=1, last_grant=id, counter cleared, state IDLE.
REQ-024 WAIT with counter == TIMEOUT-1 and ready=0: next cycle req_err[id]=1, last_grant=id, state IDLE.
REQ-025 ready=1 in the same cycle the timeout is reached SHALL count as done, not err.
REQ-026 ready while in IDLE or ISSUE SHALL be ignored.
REQ-027 Requests SHALL NOT be granted in ISSUE or WAIT; requesters hold req_valid and payload until req_accept and drop it the cycle after.
REQ-028 A new grant SHALL be possible in the cycle req_done/req_err is high (back-to-back, 1 idle cycle min between valid pulses is not required beyond FSM path).
REQ-029 Latency: req_valid sampled high in IDLE at edge n -> valid/req_accept high during cycle n+1.
REQ-030 w_strb=0 requests SHALL be issued unchanged; the arbiter never alters addr/data/strb.
REQ-031 At most one bit of req_accept, req_done, req_err SHALL be high in any cycle; never two of these for the same transaction in one cycle.

Reset
REQ-032 ARESET=1 at a rising edge SHALL force IDLE, last_grant=1, counter=0, and all outputs 0 (aw_addr, w_data, w_strb included).
REQ-033 Reset during ISSUE or WAIT SHALL abandon the transaction with no req_done/req_err pulse; a ready arriving after reset release SHALL be ignored.

Verification
REQ-034 Single: req_valid=01, addr 0, data 0x12345678, strb 0001 -> valid pulse with aw_addr=0, w_data=0x12345678, w_strb=0001; ready 3 cycles later -> req_done=01 next cycle.
REQ-035 Tie: req_valid=11 after reset -> requester 0 granted first (addr 1, strb 0011), then requester 1 (addr 3, strb 1101); two consecutive ties alternate 0,1,0,1.
REQ-036 Timeout: TIMEOUT=8, ready never asserted -> req_err[id] pulse exactly 8 cycles after the ISSUE cycle ends; busy drops in the same cycle.
REQ-037 Race: ready=1 in the final timeout cycle -> req_done pulses, req_err stays 0.
REQ-038 Reset mid-WAIT: ARESET high during WAIT, ready pulsed after release -> all outputs 0, no req_done, next request (addr 7, strb 1111) completes normally.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Two-requester round-robin arbiter that issues one write at a time to an AXI write
// master user port and aborts a transaction when ready does not arrive within TIMEOUT cycles.
module axi_write_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_data,
  input  logic [7:0]  req_strb,
  output logic [1:0]  req_accept,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic        busy,
  output logic        valid,
  output logic [31:0] aw_addr,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  input  logic        ready
);

  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          id, id_nxt;
  logic          last_grant, last_grant_nxt;
  logic [1:0]    accept_nxt, done_nxt, err_nxt;
  logic          busy_nxt, valid_nxt;
  logic [AW-1:0] addr_nxt, data_nxt;
  logic [SW-1:0] strb_nxt;
  logic          win;
  logic [1:0]    id_onehot;

  // On a tie the requester that was not served last wins.
  assign win       = (&req_valid) ? ~last_grant : req_valid[1];
  assign id_onehot = id ? 2'b10 : 2'b01;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    id_nxt         = id;
    last_grant_nxt = last_grant;
    accept_nxt     = '0;
    done_nxt       = '0;
    err_nxt        = '0;
    valid_nxt      = 1'b0;
    addr_nxt       = aw_addr;
    data_nxt       = w_data;
    strb_nxt       = w_strb;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt  = ISSUE;
          id_nxt     = win;
          valid_nxt  = 1'b1;
          accept_nxt = win ? 2'b10 : 2'b01;
          addr_nxt   = win ? req_addr[63:32] : req_addr[31:0];
          data_nxt   = win ? req_data[63:32] : req_data[31:0];
          strb_nxt   = win ? req_strb[7:4]   : req_strb[3:0];
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (ready) begin
          state_nxt      = IDLE;
          done_nxt       = id_onehot;
          last_grant_nxt = id;
          cnt_nxt        = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt      = IDLE;
          err_nxt        = id_onehot;
          last_grant_nxt = id;
          cnt_nxt        = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      cnt        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      req_accept <= '0;
      req_done   <= '0;
      req_err    <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      aw_addr    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      id         <= id_nxt;
      last_grant <= last_grant_nxt;
      req_accept <= accept_nxt;
      req_done   <= done_nxt;
      req_err    <= err_nxt;
      busy       <= busy_nxt;
      valid      <= valid_nxt;
      aw_addr    <= addr_nxt;
      w_data     <= data_nxt;
      w_strb     <= strb_nxt;
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: expected issues/completions are queued when
// stimulus is driven and compared when the arbiter produces them.
module tb_axi_write_arbiter;

  localparam int unsigned TO = 8;

  logic        ACLK;
  logic        ARESET;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic [1:0]  req_accept;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic        busy;
  logic        valid;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        ready;

  typedef struct {
    logic [1:0]  acc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } issue_t;

  typedef struct {
    logic [1:0] done;
    logic [1:0] err;
  } end_t;

  issue_t issue_q[$];
  end_t   end_q[$];
  issue_t mon_iss;
  end_t   mon_end;

  int   checks = 0;
  int   errors = 0;
  logic m_last;

  axi_write_arbiter #(.TIMEOUT(TO)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_strb   (req_strb),
    .req_accept (req_accept),
    .req_done   (req_done),
    .req_err    (req_err),
    .busy       (busy),
    .valid      (valid),
    .aw_addr    (aw_addr),
    .w_data     (w_data),
    .w_strb     (w_strb),
    .ready      (ready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge ACLK) begin
    if (valid || (|req_accept)) begin
      if (issue_q.size() == 0) begin
        check("unexp_issue", {61'b0, valid, req_accept}, 64'd0);
      end else begin
        mon_iss = issue_q.pop_front();
        check("iss_accept", {62'b0, req_accept}, {62'b0, mon_iss.acc});
        check("iss_valid", {63'b0, valid}, 64'd1);
        check("iss_addr", {32'b0, aw_addr}, {32'b0, mon_iss.addr});
        check("iss_data", {32'b0, w_data}, {32'b0, mon_iss.data});
        check("iss_strb", {60'b0, w_strb}, {60'b0, mon_iss.strb});
      end
    end
    if ((|req_done) || (|req_err)) begin
      if (end_q.size() == 0) begin
        check("unexp_end", {60'b0, req_done, req_err}, 64'd0);
      end else begin
        mon_end = end_q.pop_front();
        check("end_done", {62'b0, req_done}, {62'b0, mon_end.done});
        check("end_err", {62'b0, req_err}, {62'b0, mon_end.err});
      end
    end
    if (|{req_accept, req_done, req_err})
      check("onehot", 64'($onehot0({req_accept, req_done, req_err})), 64'd1);
  end

  function automatic issue_t mk_issue(input logic i, input logic [31:0] a0, input logic [31:0] d0,
                                      input logic [3:0] s0, input logic [31:0] a1,
                                      input logic [31:0] d1, input logic [3:0] s1);
    issue_t e;
    e.acc  = i ? 2'b10 : 2'b01;
    e.addr = i ? a1 : a0;
    e.data = i ? d1 : d0;
    e.strb = i ? s1 : s0;
    return e;
  endfunction

  // Drives a request pattern and queues the expected grant order.
  task automatic set_req(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] d0,
                         input logic [3:0] s0, input logic [31:0] a1, input logic [31:0] d1,
                         input logic [3:0] s1);
    logic first;
    first = (v == 2'b11) ? ~m_last : v[1];
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    req_strb  = {s1, s0};
    req_valid = v;
    issue_q.push_back(mk_issue(first, a0, d0, s0, a1, d1, s1));
    if (v == 2'b11) issue_q.push_back(mk_issue(~first, a0, d0, s0, a1, d1, s1));
  endtask

  task automatic wait_accept(input int exp_lat);
    int n;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      n++;
      if (|req_accept) break;
    end
    check("accept_lat", 64'(n), 64'(exp_lat));
    check("accept_busy", {63'b0, busy}, 64'd1);
  endtask

  // Called at the falling edge of the ISSUE cycle; ends either with ready after k WAIT cycles or a timeout.
  task automatic complete(input logic i, input int k, input bit give_ready);
    end_t e;
    int   edges;
    @(posedge ACLK); #1;
    req_valid[i] = 1'b0;
    if (give_ready) begin
      e.done = i ? 2'b10 : 2'b01;
      e.err  = 2'b00;
      end_q.push_back(e);
      repeat (k) begin @(posedge ACLK); #1; end
      ready = 1'b1;
      @(posedge ACLK); #1;
      ready = 1'b0;
      @(negedge ACLK);
      check("done_now", {62'b0, req_done}, {62'b0, e.done});
      check("done_noerr", {62'b0, req_err}, 64'd0);
      check("done_busy", {63'b0, busy}, 64'd0);
    end else begin
      e.done = 2'b00;
      e.err  = i ? 2'b10 : 2'b01;
      end_q.push_back(e);
      edges = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge ACLK);
        edges++;
        @(negedge ACLK);
        if (|req_err) break;
      end
      check("timeout_edges", 64'(edges), 64'(TO));
      check("timeout_err", {62'b0, req_err}, {62'b0, e.err});
      check("timeout_busy", {63'b0, busy}, 64'd0);
    end
    m_last = i;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    check({tag, "_valid"}, {63'b0, valid}, 64'd0);
    check({tag, "_addr"}, {32'b0, aw_addr}, 64'd0);
    check({tag, "_data"}, {32'b0, w_data}, 64'd0);
    check({tag, "_strb"}, {60'b0, w_strb}, 64'd0);
    check({tag, "_flags"}, {58'b0, req_accept, req_done, req_err}, 64'd0);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    m_last = 1'b1;
  endtask

  initial begin
    logic [31:0] d0, d1;
    logic [1:0]  v;
    logic        first;
    int          k;

    ARESET    = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    ready     = 1'b0;
    m_last    = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_idle_zero("reset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Single request from requester 0, ready three WAIT cycles in.
    set_req(2'b01, 32'h0, 32'h12345678, 4'b0001, 32'h0, 32'h0, 4'b0000);
    wait_accept(2);
    complete(1'b0, 3, 1'b1);

    // Ready while idle must not produce anything.
    ready = 1'b1;
    repeat (3) @(negedge ACLK);
    ready = 1'b0;
    check("idle_ready_busy", {63'b0, busy}, 64'd0);

    // Zero strobe passes through unchanged.
    d1 = $urandom;
    set_req(2'b10, 32'h0, 32'h0, 4'b0000, 32'h2000, d1, 4'b0000);
    wait_accept(1);
    complete(1'b1, 0, 1'b1);

    // Ties after reset alternate 0,1,0,1.
    do_reset();
    d0 = $urandom;
    d1 = $urandom;
    set_req(2'b11, 32'h1, d0, 4'b0011, 32'h3, d1, 4'b1101);
    wait_accept(2);
    complete(1'b0, 2, 1'b1);
    wait_accept(1);
    complete(1'b1, 1, 1'b1);
    set_req(2'b11, 32'h10, d1, 4'b1010, 32'h14, d0, 4'b0101);
    wait_accept(1);
    complete(1'b0, 0, 1'b1);
    wait_accept(1);
    complete(1'b1, 0, 1'b1);

    // Timeout with ready never asserted.
    set_req(2'b10, 32'h0, 32'h0, 4'b0000, 32'hABC0, 32'hDEAD_BEEF, 4'b1111);
    wait_accept(1);
    complete(1'b1, 0, 1'b0);

    // Ready in the final timeout cycle counts as done.
    set_req(2'b01, 32'h44, 32'h5555_AAAA, 4'b0110, 32'h0, 32'h0, 4'b0000);
    wait_accept(1);
    complete(1'b0, int'(TO) - 1, 1'b1);

    // Random mix of single and tied requests.
    for (int r = 0; r < 4; r++) begin
      v  = 2'($urandom_range(1, 3));
      k  = int'($urandom_range(0, 5));
      d0 = $urandom;
      d1 = $urandom;
      first = (v == 2'b11) ? ~m_last : v[1];
      set_req(v, 32'(r * 16), d0, 4'($urandom), 32'(r * 16 + 8), d1, 4'($urandom));
      wait_accept(1);
      complete(first, k, 1'b1);
      if (v == 2'b11) begin
        wait_accept(1);
        complete(~first, k, 1'b1);
      end
    end

    // Reset mid-WAIT abandons the transaction; a later ready is ignored.
    set_req(2'b01, 32'h5, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'h0, 4'b0000);
    wait_accept(1);
    @(posedge ACLK); #1;
    req_valid = 2'b00;
    repeat (2) begin @(posedge ACLK); #1; end
    do_reset();
    ready = 1'b1;
    @(posedge ACLK); #1;
    ready = 1'b0;
    @(negedge ACLK);
    check_idle_zero("post_reset");
    repeat (2) @(negedge ACLK);
    check("post_reset_done", {62'b0, req_done}, 64'd0);
    set_req(2'b01, 32'h7, 32'h0BAD_CAFE, 4'b1111, 32'h0, 32'h0, 4'b0000);
    wait_accept(1);
    complete(1'b0, 1, 1'b1);

    repeat (3) @(negedge ACLK);
    check("sb_issue_left", 64'(issue_q.size()), 64'd0);
    check("sb_end_left", 64'(end_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
